// File: rtl/ccc_reset_ctrl_if.sv
// Signal bundle between the CCC lock/debug sources and the reset sequencer.
// RSTGEN_LOSS_COUNT_EN adds the 8-bit lock-loss counter output.
interface ccc_reset_ctrl_if;
   logic       lock;
   logic       soft_reset_req;
   logic       sys_resetn;
   logic       core_reset;
   logic       lock_lost;
`ifdef RSTGEN_LOSS_COUNT_EN
   logic [7:0] loss_count;
`endif

`ifdef RSTGEN_LOSS_COUNT_EN
   modport master (
      output lock, soft_reset_req,
      input  sys_resetn, core_reset, lock_lost, loss_count
   );
   modport slave (
      input  lock, soft_reset_req,
      output sys_resetn, core_reset, lock_lost, loss_count
   );
`else
   modport master (
      output lock, soft_reset_req,
      input  sys_resetn, core_reset, lock_lost
   );
   modport slave (
      input  lock, soft_reset_req,
      output sys_resetn, core_reset, lock_lost
   );
`endif
endinterface

// File: rtl/ccc_reset_ctrl.sv
// Reset sequencer on CCC GL0: debounces LOCK, releases peripheral then core reset.
// Optional macro RSTGEN_LOSS_COUNT_EN enables the saturating lock-loss counter.
module ccc_reset_ctrl #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int CORE_DELAY_CYCLES  = 16
) (
   input logic             clk,
   input logic             resetn,
   ccc_reset_ctrl_if.slave bus
);

   localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > CORE_DELAY_CYCLES) ?
                               LOCK_STABLE_CYCLES : CORE_DELAY_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CORE_LAST = CW'(CORE_DELAY_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK,
      PERIPH,
      RUN,
      SOFT
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] lock_sync;
   logic [SYNC_STAGES-1:0] soft_sync;
   logic                   lock_s;
   logic                   soft_s;
   logic                   lock_loss;
   logic                   sys_resetn_r;
   logic                   core_reset_r;
   logic                   lock_lost_r;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_sync <= '0;
         soft_sync <= '0;
      end else begin
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.lock};
         soft_sync <= {soft_sync[SYNC_STAGES-2:0], bus.soft_reset_req};
      end
   end

   assign lock_s    = lock_sync[SYNC_STAGES-1];
   assign soft_s    = soft_sync[SYNC_STAGES-1];
   assign lock_loss = (state != WAIT_LOCK) && !lock_s;

   // Lock loss overrides every other transition; cnt saturates at its terminal value.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         sys_resetn_r <= 1'b0;
         core_reset_r <= 1'b1;
         lock_lost_r  <= 1'b0;
      end else if (lock_loss) begin
         state        <= WAIT_LOCK;
         cnt          <= '0;
         sys_resetn_r <= 1'b0;
         core_reset_r <= 1'b1;
         lock_lost_r  <= 1'b1;
      end else begin
         case (state)
            WAIT_LOCK: begin
               if (!lock_s) begin
                  cnt <= '0;
               end else if (cnt == LOCK_LAST) begin
                  state        <= PERIPH;
                  cnt          <= '0;
                  sys_resetn_r <= 1'b1;
                  core_reset_r <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PERIPH: begin
               if (cnt == CORE_LAST) begin
                  state        <= RUN;
                  core_reset_r <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RUN: begin
               if (soft_s) begin
                  state        <= SOFT;
                  cnt          <= '0;
                  core_reset_r <= 1'b1;
               end
            end
            SOFT: begin
               if (cnt != CORE_LAST) begin
                  cnt <= cnt + 1'b1;
               end else if (!soft_s) begin
                  state        <= RUN;
                  core_reset_r <= 1'b0;
               end
            end
            default: begin
               state        <= WAIT_LOCK;
               cnt          <= '0;
               sys_resetn_r <= 1'b0;
               core_reset_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.sys_resetn = sys_resetn_r;
   assign bus.core_reset = core_reset_r;
   assign bus.lock_lost  = lock_lost_r;

`ifdef RSTGEN_LOSS_COUNT_EN
   logic [7:0] loss_count_r;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         loss_count_r <= '0;
      end else if (lock_loss && (loss_count_r != 8'hFF)) begin
         loss_count_r <= loss_count_r + 8'd1;
      end
   end

   assign bus.loss_count = loss_count_r;
`endif

endmodule

// File: doc/ccc_reset_ctrl.md
# ccc_reset_ctrl

Reset sequencer that sits directly downstream of the fabric clock conditioning circuit (CCC). It runs on the CCC global clock GL0, synchronizes and debounces the CCC LOCK output, and releases the peripheral reset and then the CPU core reset in a fixed order once the clock is stable. A loss of lock re-asserts both resets. A debug/software request can re-reset only the core.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop depth of the LOCK and SOFT_RESET_REQ synchronizers (≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-LOCK-high cycles required before SYS_RESETN releases (≥1).
- CORE_DELAY_CYCLES, 16: cycles between SYS_RESETN release and CORE_RESET release; also the soft-reset hold length (≥1).

Ports:
- CLK  in  1  GL0 from the CCC.
- RESETN  in  1  asynchronous, active-low power-on reset. It forces all state immediately.
- LOCK  in  1  CCC lock. Asynchronous to CLK.
- SOFT_RESET_REQ  in  1  asynchronous level request to reset the core only.
- SYS_RESETN  out  1  active-low peripheral/bus reset. Registered.
- CORE_RESET  out  1  active-high VexRiscv reset. Registered.
- LOCK_LOST  out  1  sticky flag: lock dropped after first release. Cleared only by RESETN.
- LOSS_COUNT  out  8  number of lock-loss events. Present only with the configuration macro defined.

## Operation
- Synchronizers: lock_s and soft_s are the last stages of SYNC_STAGES-deep chains. Chains reset to 0.
- FSM states:
  - WAIT_LOCK (reset state): SYS_RESETN=0, CORE_RESET=1. Counter cnt increments while lock_s=1 and clears to 0 when lock_s=0. When lock_s=1 and cnt==LOCK_STABLE_CYCLES-1, go to PERIPH and clear cnt.
  - PERIPH: SYS_RESETN=1, CORE_RESET=1. cnt increments. When cnt==CORE_DELAY_CYCLES-1, go to RUN.
  - RUN: SYS_RESETN=1, CORE_RESET=0. When soft_s=1, go to SOFT and clear cnt.
  - SOFT: SYS_RESETN=1, CORE_RESET=1. cnt increments. When cnt==CORE_DELAY_CYCLES-1 and soft_s=0, go to RUN. While soft_s stays 1, remain in SOFT with cnt saturated.
- Lock loss: lock_s=0 in PERIPH, RUN or SOFT → go to WAIT_LOCK and clear cnt. On that edge, set LOCK_LOST=1 and increment LOSS_COUNT. Lock loss takes priority over every other transition.
- cnt width is $clog2(max(LOCK_STABLE_CYCLES, CORE_DELAY_CYCLES)+1). It never wraps.
- LOSS_COUNT saturates at 255.
- SOFT_RESET_REQ is ignored in WAIT_LOCK and PERIPH.
- Outputs are driven directly from registers (Moore outputs).

## Timing
- Reset values: SYS_RESETN=0, CORE_RESET=1, LOCK_LOST=0, LOSS_COUNT=0, state=WAIT_LOCK, cnt=0.
- RESETN assertion takes effect asynchronously. Deassertion is assumed synchronous to CLK at the board/top level.
- LOCK rise to lock_s=1: SYNC_STAGES edges.
- lock_s first high to SYS_RESETN=1: LOCK_STABLE_CYCLES edges.
- SYS_RESETN rise to CORE_RESET fall: CORE_DELAY_CYCLES edges.
- LOCK fall to SYS_RESETN=0 and CORE_RESET=1: SYNC_STAGES+1 edges.
- LOCK glitches of fewer than LOCK_STABLE_CYCLES synchronized cycles in WAIT_LOCK restart the count.
- Soft request: CORE_RESET=1 one edge after soft_s rises. Minimum high time is CORE_DELAY_CYCLES cycles. CORE_RESET falls one edge after soft_s=0 once the minimum has elapsed.

## Configuration
- RSTGEN_LOSS_COUNT_EN defined: the LOSS_COUNT port and its 8-bit saturating counter are present.
- Not defined: the port and counter are absent. LOCK_LOST behaviour is unchanged.

## Test plan
All scenarios use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, CORE_DELAY_CYCLES=4.
- Power-up: RESETN low 5 cycles, LOCK=0 → SYS_RESETN=0, CORE_RESET=1, LOCK_LOST=0 throughout. With LOCK=0 after RESETN release, no change for 100 cycles.
- Clean lock: LOCK rises at edge 0 → SYS_RESETN=1 at edge 10. CORE_RESET=0 at edge 14.
- Glitch: LOCK high 5 cycles, low 1, then high → the count restarts. SYS_RESETN rises 8 cycles after the second synchronized rise.
- Lock loss in RUN: LOCK falls → SYS_RESETN=0 and CORE_RESET=1 after 3 edges. LOCK_LOST=1 and LOSS_COUNT=1. LOCK re-rises → the full sequence repeats and LOCK_LOST stays 1.
- Soft reset: 1-cycle SOFT_RESET_REQ pulse in RUN → CORE_RESET high for exactly 4 cycles and SYS_RESETN stays 1. A 10-cycle request holds CORE_RESET until 1 edge after soft_s falls.
- Lock loss during SOFT, and async RESETN mid-PERIPH → WAIT_LOCK in both cases. RESETN clears LOCK_LOST and LOSS_COUNT immediately.
